fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and flag controller for the 128 x 8 output-buffer FIFO memory. It turns a single-clock push/pop interface into the memory's write enable, write address and read address, and it keeps the full flag that the memory array uses to gate writes. It also reports occupancy, almost-full/almost-empty thresholds and sticky overflow/underflow errors to the output-buffer top level.

## Interface
- `ADDR_BITS`, default 7: memory address width; depth = 2^ADDR_BITS = 128.
- `AF_THRESH`, default 120: `almost_full` asserts when `count >= AF_THRESH`.
- `AE_THRESH`, default 8: `almost_empty` asserts when `count <= AE_THRESH`.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `push` in 1: write request; data is presented to the memory by the producer.
- `pop` in 1: read request; consumes the word currently on memory `data_out`.
- `clear` in 1: synchronous flush.
- `w_en` out 1: memory write enable.
- `w_count` out 7: memory write address.
- `r_count` out 7: memory read address (head of queue).
- `full` out 1: FIFO full; also drives the memory `full` input.
- `empty` out 1: FIFO empty; memory `data_out` is valid whenever `empty` = 0.
- `almost_full` out 1: occupancy threshold flag.
- `almost_empty` out 1: occupancy threshold flag.
- `count` out 8: occupancy, 0..128.
- `overflow` out 1: sticky flag, push attempted while full.
- `underflow` out 1: sticky flag, pop attempted while empty.

## Operation
- Write and read pointers are ADDR_BITS+1 = 8 bits wide. The low 7 bits are the address and the MSB is the wrap bit.
- `w_count` = wptr[6:0] and `r_count` = rptr[6:0].
- `empty` = (wptr == rptr).
- `full` = (addresses equal) and (wrap bits differ).
- Accepted push: `push_ok = push & ~full & ~clear`. Then `w_en = push_ok` (combinational) and wptr increments modulo 256.
- Accepted pop: `pop_ok = pop & ~empty & ~clear`. rptr increments modulo 256.
- `count` = wptr − rptr, computed modulo 256 and held in a register.
  - push_ok only: +1.
  - pop_ok only: −1.
  - both or neither: unchanged.
- Full plus simultaneous push and pop: the pop is accepted and the push is rejected. `w_en` = 0, `overflow` sets, and the FIFO is no longer full next cycle.
- Empty plus simultaneous push and pop: the push is accepted and the pop is rejected (no fall-through). `underflow` sets.
- `clear` has priority over push and pop. Next edge:
  - both pointers go to 0 and `count` goes to 0;
  - `overflow` and `underflow` are cleared;
  - `w_en` = 0 during the clear cycle.
- Pointer wrap: address 127 wraps to 0 and the wrap bit toggles. No other effect.
- The controller never clears memory contents. Stale words are unreachable because they are never inside the rptr..wptr window.

## Timing
- Reset values:
  - wptr = rptr = 0, so `w_count` = `r_count` = 0;
  - `full` = 0, `empty` = 1, `count` = 0;
  - `almost_full` = 0, `almost_empty` = 1;
  - `overflow` = `underflow` = 0;
  - `w_en` = 0 (`push_ok` is 0 while `full`/`clear` gating holds; `w_en` is only high when `push` is high).
- Reset asserted mid-operation: all state returns to the reset values immediately, without waiting for a clock edge.
- All outputs except `w_en` are registered, or are decoded only from registered pointers.
- Flags and `count` reflect an accepted push or pop one cycle after the edge that samples it.
- Write latency: the word is written on the edge where `w_en` = 1. It is visible on `data_out` when `empty` falls, which is the next cycle.
- Read: `data_out` = mem[`r_count`] is combinational. The consumer samples it in the same cycle it asserts `pop`. The next word is presented after the edge.
- Sustained throughput: one push and one pop per cycle.

## Structure
- Package `fifo_pkg` holds:
  - `localparam ADDR_BITS = 7`, `DEPTH = 128`, `PTR_BITS = 8`;
  - `typedef logic [PTR_BITS-1:0] ptr_t`;
  - `typedef logic [PTR_BITS-1:0] cnt_t`.
- Sub-module `fifo_ptr` is a natural split:
  - an 8-bit wrapping pointer register with async active-low reset, synchronous clear and an increment enable;
  - instantiated twice, once for write and once for read.
- `fifo_ctrl` contains the accept logic, flag decode, `count` register and sticky error registers.
- The output-buffer top instantiates `fifo_ctrl` alongside the memory array.

## Test plan
- Reset, then 128 pushes with no pop:
  - `w_count` runs 0..127;
  - `count` = 128 and `full` = 1;
  - `almost_full` rises in the cycle after push 120.
- While full, `push` = 1 for one cycle: `w_en` = 0, `overflow` = 1 and sticky, `count` stays 128, and memory is unchanged.
- Empty FIFO with `pop` = 1: `underflow` = 1 and `r_count` stays 0. Then push and pop together while empty: `count` = 1 and rptr is unchanged.
- Wrap test:
  - push and pop simultaneously for 300 cycles after preloading 5 words;
  - `count` holds at 5;
  - pointers wrap 127 → 0 and the wrap bit toggles;
  - data order is preserved.
- `clear` asserted together with `push` and `pop` at `count` = 50: `w_en` = 0, next cycle `count` = 0, `empty` = 1, and both error flags are 0.
- `n_rst` pulsed low mid-stream at `count` = 77: outputs take their reset values before the next `clk` edge, and normal operation resumes after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing and types for the 128 x 8 output-buffer FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_pkg;

  localparam int ADDR_BITS = 7;
  localparam int DEPTH     = 128;
  localparam int PTR_BITS  = 8;

  // Pointers carry one extra wrap bit above the memory address.
  typedef logic [PTR_BITS-1:0] ptr_t;
  // Occupancy needs the same width so that DEPTH itself is representable.
  typedef logic [PTR_BITS-1:0] cnt_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Push/pop request and status bundle between the FIFO controller and its user.
// Latency: n/a (wiring only).
// Backpressure: user watches full/empty; rejected requests only raise sticky errors.
// Ports: push/pop/clear from the user; w_en, w_count, r_count, full, empty,
//        almost_full, almost_empty, count, overflow, underflow from the controller.
interface fifo_ctrl_if import fifo_pkg::*; #(
  parameter int ADDR_BITS = fifo_pkg::ADDR_BITS
);

  logic                 push;
  logic                 pop;
  logic                 clear;
  logic                 w_en;
  logic [ADDR_BITS-1:0] w_count;
  logic [ADDR_BITS-1:0] r_count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_BITS:0]   count;
  logic                 overflow;
  logic                 underflow;

  // Producer/consumer side.
  modport master (
    output push, pop, clear,
    input  w_en, w_count, r_count, full, empty,
    input  almost_full, almost_empty, count, overflow, underflow
  );

  // Controller side.
  modport slave (
    input  push, pop, clear,
    output w_en, w_count, r_count, full, empty,
    output almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: address bits plus a wrap bit, modulo 2^PTR_BITS.
// Latency: one cycle from inc/clr to the new pointer value.
// Backpressure: none; the caller gates inc.
// Ports: clk, n_rst (async active-low), clr (sync, wins over inc), inc, ptr.
module fifo_ptr import fifo_pkg::*; #(
  parameter int PTR_BITS = fifo_pkg::PTR_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clr,
  input  logic                inc,
  output logic [PTR_BITS-1:0] ptr
);

  // Natural overflow of the adder performs both the address wrap and the
  // wrap-bit toggle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the output-buffer FIFO memory.
// Latency: w_en combinational from push; flags/count update one cycle after the accepting edge.
// Backpressure: push refused while full, pop refused while empty; refusals set sticky errors.
// Ports: clk, n_rst (async active-low), bus (fifo_ctrl_if.slave: push/pop/clear in,
//        write enable, addresses, flags, count and sticky errors out).
module fifo_ctrl import fifo_pkg::*; #(
  parameter int ADDR_BITS = fifo_pkg::ADDR_BITS,
  parameter int AF_THRESH = 120,
  parameter int AE_THRESH = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  fifo_ctrl_if.slave bus
);

  localparam int PW = ADDR_BITS + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_q;
  logic          unf_q;

  // Flags decode only from registered pointers.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_BITS-1:0] == rptr[ADDR_BITS-1:0]) &&
                 (wptr[ADDR_BITS] != rptr[ADDR_BITS]);

  // Gating on the current flags means a full FIFO takes only the pop of a
  // simultaneous pair, and an empty FIFO takes only the push (no fall-through).
  assign push_ok = bus.push && !full  && !bus.clear;
  assign pop_ok  = bus.pop  && !empty && !bus.clear;

  fifo_ptr #(.PTR_BITS(PW)) u_wptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (bus.clear),
    .inc   (push_ok),
    .ptr   (wptr)
  );

  fifo_ptr #(.PTR_BITS(PW)) u_rptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (bus.clear),
    .inc   (pop_ok),
    .ptr   (rptr)
  );

  // Occupancy kept as its own register so threshold compares see a flop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (bus.clear) begin
      count_q <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky errors: any refused request while full/empty, cleared only by
  // clear or reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.push && full) ovf_q <= 1'b1;
      if (bus.pop && empty) unf_q <= 1'b1;
    end
  end

  assign bus.w_en         = push_ok;
  assign bus.w_count      = wptr[ADDR_BITS-1:0];
  assign bus.r_count      = rptr[ADDR_BITS-1:0];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_LVL);
  assign bus.almost_empty = (count_q <= AE_LVL);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural memory and data scoreboard.
// Latency: checks w_en mid-cycle and registered state 1 time unit after each edge.
// Backpressure: bench model decides acceptance from its own occupancy.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic clk;
  logic n_rst;
  logic [7:0] wdata;
  logic [7:0] mem [DEPTH];
  logic [7:0] data_out;

  fifo_ctrl_if bus ();

  fifo_ctrl u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory array driven by the controller's write port.
  always @(posedge clk) begin
    if (bus.w_en) mem[bus.w_count] <= wdata;
  end
  assign data_out = mem[bus.r_count];

  int unsigned n_tests;
  int unsigned n_fail;
  int          mw, mr, mcnt;
  bit          movf, munf;
  logic [7:0]  sb [$];
  logic [7:0]  seq;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mw = 0; mr = 0; mcnt = 0; movf = 0; munf = 0;
    sb.delete();
  endtask

  task automatic check_state(input string ph);
    chk({ph, ":w_count"},      bus.w_count,      mw & 127);
    chk({ph, ":r_count"},      bus.r_count,      mr & 127);
    chk({ph, ":count"},        bus.count,        mcnt);
    chk({ph, ":full"},         bus.full,         (mcnt == DEPTH) ? 1 : 0);
    chk({ph, ":empty"},        bus.empty,        (mcnt == 0) ? 1 : 0);
    chk({ph, ":almost_full"},  bus.almost_full,  (mcnt >= 120) ? 1 : 0);
    chk({ph, ":almost_empty"}, bus.almost_empty, (mcnt <= 8) ? 1 : 0);
    chk({ph, ":overflow"},     bus.overflow,     movf);
    chk({ph, ":underflow"},    bus.underflow,    munf);
  endtask

  // One clock of stimulus: entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit p, input bit q, input bit c);
    bit mfull, mempty, pok, qok;
    logic [7:0] exp_d;
    mfull  = (mcnt == DEPTH);
    mempty = (mcnt == 0);
    pok = p && !mfull && !c;
    qok = q && !mempty && !c;
    wdata     = seq;
    bus.push  = p;
    bus.pop   = q;
    bus.clear = c;
    #4;
    chk("w_en", bus.w_en, pok);
    if (qok) begin
      exp_d = sb.pop_front();
      chk("data_out", data_out, exp_d);
    end
    if (pok) begin
      sb.push_back(seq);
      seq = seq + 8'd1;
    end
    if (c) begin
      model_reset();
    end else begin
      if (pok) mw = (mw + 1) % 256;
      if (qok) mr = (mr + 1) % 256;
      mcnt = mcnt + (pok ? 1 : 0) - (qok ? 1 : 0);
      if (p && mfull)  movf = 1;
      if (q && mempty) munf = 1;
    end
    @(posedge clk);
    #1;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.clear = 1'b0;
    check_state("cyc");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; seq = 8'd0;
    n_rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; wdata = '0;
    model_reset();
    #3;
    check_state("reset");
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;

    // Fill to full; almost_full tracked every cycle by check_state.
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0);
    cyc(1, 0, 0);                      // push while full -> overflow
    cyc(0, 0, 0);                      // overflow stays set
    cyc(1, 1, 0);                      // full + both: pop wins
    while (mcnt > 0) cyc(0, 1, 0);
    cyc(0, 1, 0);                      // pop while empty -> underflow
    cyc(1, 1, 0);                      // empty + both: push wins
    cyc(0, 1, 0);

    // Preload 5 then stream through several pointer wraps.
    for (int i = 0; i < 5; i++)   cyc(1, 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, 1, 0);

    // Clear dominates push+pop at count = 50.
    while (mcnt < 50) cyc(1, 0, 0);
    cyc(1, 1, 1);

    // Asynchronous reset mid-stream at count = 77.
    for (int i = 0; i < 77; i++) cyc(1, 0, 0);
    n_rst = 1'b0;
    #2;
    model_reset();
    check_state("midrst");
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    check_state("postrst");
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    for (int i = 0; i < 6; i++)  cyc(1, 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
